// File: rtl/sipo_word_collector.sv
// Serial-in parallel-out word collector: shifts in one bit per qualified clock
// and hands each completed WIDTH-bit word to a one-entry valid/ready register.
module sipo_word_collector #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             resync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic [5:0]       bit_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t       state_q;
  out_state_t       state_d;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic             take_bit;
  logic             complete;
  logic             load;
  logic             drop;

  // Shifted value already contains this edge's bit, so a completed word can be
  // loaded into dout on the same edge as its last bit.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sr[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign shifted = {sin, sr[WIDTH-1:1]};
    end
  endgenerate

  assign take_bit   = sin_valid && !resync;
  assign complete   = take_bit && (bit_cnt == 6'(WIDTH - 1));
  assign dout_valid = (state_q == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A full register accepts a new word only if the consumer takes the old one
  // on the same edge; otherwise the new word is dropped.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (dout_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (dout_ready) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      if (resync) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (sin_valid) begin
        sr      <= shifted;
        bit_cnt <= complete ? 6'd0 : bit_cnt + 6'd1;
      end
      if (load) begin
        dout <= shifted;
      end
      // A drop on the same edge as a clear request leaves the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_word_collector.sv
// Bench for sipo_word_collector: MSB-first and LSB-first instances share all
// inputs and are compared against a bit-queue model of word assembly.
module tb_sipo_word_collector;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       resync;
  logic       dout_ready;
  logic       ovr_clr;

  logic [3:0] dout_m;
  logic       dv_m;
  logic       ovr_m;
  logic [5:0] cnt_m;
  logic [3:0] dout_l;
  logic       dv_l;
  logic       ovr_l;
  logic [5:0] cnt_l;

  int checks;
  int errors;

  // Reference model: received bits in arrival order plus output register.
  logic       q[$];
  logic       m_valid;
  logic       m_ovr;
  logic [3:0] m_msb;
  logic [3:0] m_lsb;

  logic [23:0] obs;
  assign obs = {dv_m, ovr_m, cnt_m, dout_m, dv_l, ovr_l, cnt_l, dout_l};

  sipo_word_collector #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .resync     (resync),
    .dout       (dout_m),
    .dout_valid (dv_m),
    .dout_ready (dout_ready),
    .overrun    (ovr_m),
    .ovr_clr    (ovr_clr),
    .bit_cnt    (cnt_m)
  );

  sipo_word_collector #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .resync     (resync),
    .dout       (dout_l),
    .dout_valid (dv_l),
    .dout_ready (dout_ready),
    .overrun    (ovr_l),
    .ovr_clr    (ovr_clr),
    .bit_cnt    (cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] model_vec();
    logic [5:0] c;
    c = 6'(q.size());
    return {m_valid, m_ovr, c, m_msb, m_valid, m_ovr, c, m_lsb};
  endfunction

  task automatic model_edge();
    logic       done;
    logic       dropped;
    logic [3:0] wm;
    logic [3:0] wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_msb   = '0;
      m_lsb   = '0;
    end else begin
      if (resync) begin
        q.delete();
      end else if (sin_valid) begin
        q.push_back(sin);
        if (q.size() == 4) begin
          done = 1'b1;
          for (int i = 0; i < 4; i++) begin
            wm[3 - i] = q[i];
            wl[i]     = q[i];
          end
          q.delete();
        end
      end
      dropped = done && m_valid && !dout_ready;
      if (done && !dropped) begin
        m_msb   = wm;
        m_lsb   = wl;
        m_valid = 1'b1;
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
      if (dropped) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v,
                      input logic rs, input logic rdy, input logic clr);
    rst_n      = r;
    sin        = s;
    sin_valid  = v;
    resync     = rs;
    dout_ready = rdy;
    ovr_clr    = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // seq[3] is the first bit on the wire.
  task automatic send_word(input logic [3:0] seq, input logic rdy);
    for (int i = 3; i >= 0; i--) step(1'b1, seq[i], 1'b1, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h want=%h", obs, 24'h0);
    end
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("[TB] FAIL reset_model got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] seq;
    logic [5:0] cnt_exp[4];
    seq = 4'b1100;
    cnt_exp = '{6'd1, 6'd2, 6'd3, 6'd0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[3 - i], 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cnt_m !== cnt_exp[i]) begin
        errors++;
        $display("[TB] FAIL msb_bit_cnt step=%0d got=%0d want=%0d", i, cnt_m, cnt_exp[i]);
      end
    end
    checks++;
    if (dout_m !== 4'b1100 || dv_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL msb_word got=%b/%b want=1100/1", dout_m, dv_m);
    end
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("[TB] FAIL msb_model got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_lsb_first();
    drain();
    send_word(4'b0110, 1'b0);
    checks++;
    if (dout_l !== 4'b0110 || dv_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsb_word got=%b/%b want=0110/1", dout_l, dv_l);
    end
    drain();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dv_l !== 1'b0 || cnt_l !== 6'd3) begin
      errors++;
      $display("[TB] FAIL lsb_gap_early got=%b/%0d want=0/3", dv_l, cnt_l);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dout_l !== 4'b0110 || dv_l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lsb_gap_word got=%b/%b want=0110/1", dout_l, dv_l);
    end
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("[TB] FAIL lsb_model got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_overrun();
    drain();
    send_word(4'b1100, 1'b0);
    send_word(4'b0110, 1'b0);
    checks++;
    if (dout_m !== 4'b1100 || ovr_m !== 1'b1 || dv_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_drop got=%b/%b/%b want=1100/1/1", dout_m, ovr_m, dv_m);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_clear got=%b/%b want=0/0", ovr_m, ovr_l);
    end
    // Drop and clear on the same edge: the drop must win.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr_m !== 1'b1 || dout_m !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL overrun_set_wins got=%b/%b want=1/1100", ovr_m, dout_m);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("[TB] FAIL overrun_model got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    drain();
    send_word(4'b1100, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dv_m !== 1'b1 || dout_m !== 4'b0110 || ovr_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back got=%b/%b/%b want=1/0110/0", dv_m, dout_m, ovr_m);
    end
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("[TB] FAIL b2b_model got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_resync();
    drain();
    drain();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cnt_m !== 6'd0 || dv_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resync_cnt got=%0d/%b want=0/0", cnt_m, dv_m);
    end
    send_word(4'b1010, 1'b0);
    checks++;
    if (dout_m !== 4'b1010 || dv_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resync_word got=%b/%b want=1010/1", dout_m, dv_m);
    end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("[TB] FAIL midword_reset got=%h want=%h", obs, 24'h0);
    end
    send_word(4'b1001, 1'b0);
    checks++;
    if (dout_m !== 4'b1001 || dout_l !== 4'b1001 || dv_m !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_word got=%b/%b/%b want=1001/1001/1", dout_m, dout_l, dv_m);
    end
  endtask

  task automatic test_random();
    logic r;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      step(r, 1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           1'($urandom), ($urandom_range(0, 9) == 0));
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random step=%0d got=%h want=%h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_valid    = 1'b0;
    m_ovr      = 1'b0;
    m_msb      = '0;
    m_lsb      = '0;
    rst_n      = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    resync     = 1'b0;
    dout_ready = 1'b0;
    ovr_clr    = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
